// File: rtl/ascon_mode_arbiter.sv
// Hands the Ascon core control and the output stream to one of NUM_FSM sub-FSMs
// for the duration of an operation; the output stream passes through a 2-entry FIFO.
module ascon_mode_arbiter #(
    parameter int NUM_FSM  = 2,
    parameter int CTRL_W   = 16,
    parameter int DATA_W   = 64,
    localparam int KEEP_W = DATA_W / 8,
    localparam int USER_W = 3,
    localparam int SEL_W  = $clog2(NUM_FSM)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic [SEL_W-1:0]           sel_i,
    input  logic                       abort_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       aborted_o,
    output logic                       start_err_o,
    output logic [SEL_W-1:0]           active_sel_o,
    output logic [NUM_FSM-1:0]         fsm_start_o,
    output logic [NUM_FSM-1:0]         fsm_abort_o,
    input  logic [NUM_FSM-1:0]         fsm_busy_i,
    input  logic [NUM_FSM-1:0]         fsm_done_i,
    input  logic [NUM_FSM*CTRL_W-1:0]  fsm_ctrl_i,
    output logic [CTRL_W-1:0]          core_ctrl_o,
    input  logic [NUM_FSM-1:0]         fsm_s_tready_i,
    output logic                       padded_tready_o,
    input  logic [NUM_FSM*DATA_W-1:0]  fsm_m_tdata_i,
    input  logic [NUM_FSM*KEEP_W-1:0]  fsm_m_tkeep_i,
    input  logic [NUM_FSM*USER_W-1:0]  fsm_m_tuser_i,
    input  logic [NUM_FSM-1:0]         fsm_m_tlast_i,
    input  logic [NUM_FSM-1:0]         fsm_m_tvalid_i,
    output logic [NUM_FSM-1:0]         fsm_m_tready_o,
    output logic [DATA_W-1:0]          m_axis_tdata,
    output logic [KEEP_W-1:0]          m_axis_tkeep,
    output logic [USER_W-1:0]          m_axis_tuser,
    output logic                       m_axis_tlast,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DRAIN,
        S_FLUSH
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic [USER_W-1:0] user;
        logic              last;
    } beat_t;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   active_sel_q, active_sel_d;
    logic               start_pend_q, start_pend_d;
    logic               start_err_q, start_err_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;
    logic               flush;

    logic [1:0]         count_q;
    logic               rd_ptr_q, wr_ptr_q;
    beat_t              mem_q [2];
    beat_t              head;

    logic [NUM_FSM-1:0] sel_onehot;
    logic               sel_busy, sel_done, sel_s_tready, sel_m_tvalid;
    logic [CTRL_W-1:0]  sel_ctrl;
    beat_t              sel_beat;

    logic               sel_ok, stream_open, fifo_full, push, pop;

    // Demultiplex every per-FSM bundle down to the one owned by the latched index.
    always_comb begin
        sel_onehot   = '0;
        sel_busy     = 1'b0;
        sel_done     = 1'b0;
        sel_s_tready = 1'b0;
        sel_m_tvalid = 1'b0;
        sel_ctrl     = '0;
        sel_beat     = '0;
        for (int i = 0; i < NUM_FSM; i++) begin
            if (active_sel_q == SEL_W'(i)) begin
                sel_onehot[i]  = 1'b1;
                sel_busy       = fsm_busy_i[i];
                sel_done       = fsm_done_i[i];
                sel_s_tready   = fsm_s_tready_i[i];
                sel_m_tvalid   = fsm_m_tvalid_i[i];
                sel_ctrl       = fsm_ctrl_i[i*CTRL_W +: CTRL_W];
                sel_beat.data  = fsm_m_tdata_i[i*DATA_W +: DATA_W];
                sel_beat.keep  = fsm_m_tkeep_i[i*KEEP_W +: KEEP_W];
                sel_beat.user  = fsm_m_tuser_i[i*USER_W +: USER_W];
                sel_beat.last  = fsm_m_tlast_i[i];
            end
        end
    end

    assign sel_ok      = 32'(sel_i) < 32'(NUM_FSM);
    assign stream_open = (state_q == S_ACTIVE) || (state_q == S_DRAIN);
    assign fifo_full   = (count_q == 2'd2);
    assign push        = stream_open && sel_m_tvalid && !fifo_full;
    assign pop         = (count_q != 2'd0) && m_axis_tready;

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        active_sel_d = active_sel_q;
        start_pend_d = 1'b0;
        start_err_d  = 1'b0;
        done_d       = 1'b0;
        aborted_d    = 1'b0;
        flush        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (sel_ok) begin
                        active_sel_d = sel_i;
                        start_pend_d = 1'b1;
                        state_d      = S_ACTIVE;
                    end else begin
                        start_err_d = 1'b1;
                    end
                end
            end
            S_ACTIVE: begin
                start_err_d = start_i;
                if (abort_i) begin
                    state_d = S_FLUSH;
                    flush   = 1'b1;
                end else if (sel_done) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                start_err_d = start_i;
                if (abort_i) begin
                    state_d = S_FLUSH;
                    flush   = 1'b1;
                end else if (count_q == 2'd0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_FLUSH: begin
                start_err_d = start_i;
                if (!sel_busy) begin
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            active_sel_q <= '0;
            start_pend_q <= 1'b0;
            start_err_q  <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            active_sel_q <= active_sel_d;
            start_pend_q <= start_pend_d;
            start_err_q  <= start_err_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
        end
    end

    // An abort wins over a same-cycle push or pop: the queue restarts empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else if (flush) begin
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the storage is not reset; the outputs below are masked whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= sel_beat;
    end

    assign head            = mem_q[rd_ptr_q];
    assign m_axis_tvalid   = (count_q != 2'd0);
    assign m_axis_tdata    = m_axis_tvalid ? head.data : '0;
    assign m_axis_tkeep    = m_axis_tvalid ? head.keep : '0;
    assign m_axis_tuser    = m_axis_tvalid ? head.user : '0;
    assign m_axis_tlast    = m_axis_tvalid && head.last;

    assign busy_o          = (state_q != S_IDLE);
    assign done_o          = done_q;
    assign aborted_o       = aborted_q;
    assign start_err_o     = start_err_q;
    assign active_sel_o    = active_sel_q;
    assign fsm_start_o     = start_pend_q ? sel_onehot : '0;
    assign fsm_abort_o     = (state_q == S_FLUSH) ? sel_onehot : '0;
    assign fsm_m_tready_o  = (stream_open && !fifo_full) ? sel_onehot : '0;
    assign core_ctrl_o     = busy_o ? sel_ctrl : '0;
    assign padded_tready_o = busy_o && sel_s_tready;

endmodule
